// File: rtl/pix_pkg.sv
// Shared pixel/word types and lane geometry for the pixel packer and the
// contrast/brightness stage it feeds.
package pix_pkg;

  localparam int PIX_W  = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = 32;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [1:0]        lane_idx_t;
  typedef logic [2:0]        byte_cnt_t;

  localparam lane_idx_t LAST_LANE = 2'd3;

endpackage

// File: rtl/pixel_word_packer_if.sv
// Pixel-in / word-out handshake bundle of the packer. The packer uses the
// slave view; the pixel source and word sink together use the master view.
interface pixel_word_packer_if;
  import pix_pkg::*;

  pixel_t    in_pix;
  logic      in_valid;
  logic      in_last;
  logic      in_ready;
  word_t     out_word;
  logic      out_valid;
  logic      out_last;
  byte_cnt_t out_bytes;
  logic      out_ready;

  modport slave (
    input  in_pix, in_valid, in_last, out_ready,
    output in_ready, out_word, out_valid, out_last, out_bytes
  );

  modport master (
    output in_pix, in_valid, in_last, out_ready,
    input  in_ready, out_word, out_valid, out_last, out_bytes
  );

endinterface

// File: rtl/pix_out_reg.sv
// One-entry registered valid/ready holding stage for a packed word with its
// last flag and byte count.
module pix_out_reg
  import pix_pkg::*;
(
  input  logic      clk,
  input  logic      n_rst,
  input  logic      clear,
  input  logic      load_i,
  input  word_t     word_i,
  input  logic      last_i,
  input  byte_cnt_t bytes_i,
  input  logic      ready_i,
  output logic      ready_o,
  output logic      valid_o,
  output word_t     word_o,
  output logic      last_o,
  output byte_cnt_t bytes_o
);

  logic      valid_q, valid_d;
  word_t     word_q,  word_d;
  logic      last_q,  last_d;
  byte_cnt_t bytes_q, bytes_d;

  // Space is available when empty or when the held word drains this cycle.
  assign ready_o = !valid_q | ready_i;

  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    last_d  = last_q;
    bytes_d = bytes_q;
    if (clear) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
      bytes_d = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      word_d  = word_i;
      last_d  = last_i;
      bytes_d = bytes_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      last_q  <= 1'b0;
      bytes_q <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
      last_q  <= last_d;
      bytes_q <= bytes_d;
    end
  end

  assign valid_o = valid_q;
  assign word_o  = word_q;
  assign last_o  = last_q;
  assign bytes_o = bytes_q;

endmodule

// File: rtl/pixel_word_packer.sv
// Packs a serial 8-bit pixel stream into 32-bit words (first pixel in [31:24]),
// padding short end-of-frame words. Optional stats: PIXEL_WORD_PACKER_STATS_EN.
module pixel_word_packer
  import pix_pkg::*;
#(
  parameter pixel_t PAD_VALUE = 8'h00
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clear,
  pixel_word_packer_if.slave bus
`ifdef PIXEL_WORD_PACKER_STATS_EN
  ,
  output logic [15:0]        frame_pix_cnt,
  output logic               overflow_err
`endif
);

  lane_idx_t lane_q, lane_d;
  word_t     gather_q, gather_d;
  word_t     word_nxt;
  logic      in_rdy;
  logic      acc;
  logic      complete;
  byte_cnt_t bytes_nxt;

  // Lanes below the write lane keep gathered pixels, lanes above get padding.
  function automatic word_t pack_lanes(word_t gather, lane_idx_t lane, pixel_t pix);
    word_t res;
    res = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(lane))
        res[WORD_W-PIX_W*(i+1) +: PIX_W] = gather[WORD_W-PIX_W*(i+1) +: PIX_W];
      else if (i == int'(lane))
        res[WORD_W-PIX_W*(i+1) +: PIX_W] = pix;
      else
        res[WORD_W-PIX_W*(i+1) +: PIX_W] = PAD_VALUE;
    end
    return res;
  endfunction

  assign acc       = bus.in_valid & in_rdy;
  assign complete  = acc & ((lane_q == LAST_LANE) | bus.in_last);
  assign word_nxt  = pack_lanes(gather_q, lane_q, bus.in_pix);
  assign bytes_nxt = {1'b0, lane_q} + 3'd1;

  always_comb begin
    lane_d   = lane_q;
    gather_d = gather_q;
    if (clear) begin
      lane_d = '0;
    end else if (acc) begin
      gather_d = word_nxt;
      lane_d   = complete ? '0 : lane_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lane_q   <= '0;
      gather_q <= '0;
    end else begin
      lane_q   <= lane_d;
      gather_q <= gather_d;
    end
  end

  pix_out_reg u_out_reg (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (clear),
    .load_i  (complete),
    .word_i  (word_nxt),
    .last_i  (bus.in_last),
    .bytes_i (bytes_nxt),
    .ready_i (bus.out_ready),
    .ready_o (in_rdy),
    .valid_o (bus.out_valid),
    .word_o  (bus.out_word),
    .last_o  (bus.out_last),
    .bytes_o (bus.out_bytes)
  );

  assign bus.in_ready = in_rdy;

`ifdef PIXEL_WORD_PACKER_STATS_EN
  logic [15:0] cnt_q, cnt_d;
  logic        last_seen_q, last_seen_d;
  logic        ovf_q, ovf_d;

  function automatic logic [15:0] sat_inc(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // The count including the last pixel is visible for one cycle, then restarts.
  always_comb begin
    cnt_d       = last_seen_q ? 16'd0 : cnt_q;
    if (acc)
      cnt_d = sat_inc(cnt_d);
    last_seen_d = acc & bus.in_last;
    ovf_d       = ovf_q | (cnt_d == 16'hFFFF);
    if (clear) begin
      cnt_d       = '0;
      last_seen_d = 1'b0;
      ovf_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q       <= '0;
      last_seen_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      last_seen_q <= last_seen_d;
      ovf_q       <= ovf_d;
    end
  end

  assign frame_pix_cnt = cnt_q;
  assign overflow_err  = ovf_q;
`endif

endmodule

// File: tb/tb_pixel_word_packer.sv
// Bench for pixel_word_packer: two instances (pad 00 and pad FF) share one
// stimulus stream; a cycle model feeds a scoreboard of expected words.
module tb_pixel_word_packer;
  import pix_pkg::*;

  logic clk = 1'b0;
  logic n_rst;
  logic clear;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pixel_word_packer_if bus0 ();
  pixel_word_packer_if bus1 ();

  assign bus1.in_pix    = bus0.in_pix;
  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_last   = bus0.in_last;
  assign bus1.out_ready = bus0.out_ready;

`ifdef PIXEL_WORD_PACKER_STATS_EN
  logic [15:0] cnt0, cnt1;
  logic        ovf0, ovf1;
`endif

  pixel_word_packer #(.PAD_VALUE(8'h00)) dut0 (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .bus   (bus0)
`ifdef PIXEL_WORD_PACKER_STATS_EN
    ,
    .frame_pix_cnt (cnt0),
    .overflow_err  (ovf0)
`endif
  );

  pixel_word_packer #(.PAD_VALUE(8'hFF)) dut1 (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .bus   (bus1)
`ifdef PIXEL_WORD_PACKER_STATS_EN
    ,
    .frame_pix_cnt (cnt1),
    .overflow_err  (ovf1)
`endif
  );

  typedef struct {
    word_t     w0;
    word_t     w1;
    logic      last;
    byte_cnt_t bytes;
  } exp_t;

  exp_t      sb_q[$];
  logic      m_valid;
  lane_idx_t m_lane;
  pixel_t    m_pix [4];
  logic      m_rdy, m_acc, m_cmp;

  assign m_rdy = !m_valid | bus0.out_ready;
  assign m_acc = bus0.in_valid & m_rdy;
  assign m_cmp = m_acc & ((m_lane == 2'd3) | bus0.in_last);

  function automatic word_t exp_word(pixel_t pad);
    word_t r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(m_lane))       r[31-8*i -: 8] = m_pix[i];
      else if (i == int'(m_lane)) r[31-8*i -: 8] = bus0.in_pix;
      else                        r[31-8*i -: 8] = pad;
    end
    return r;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_valid <= 1'b0;
      m_lane  <= '0;
      sb_q.delete();
    end else if (clear) begin
      m_valid <= 1'b0;
      m_lane  <= '0;
    end else if (m_cmp) begin
      sb_q.push_back(exp_t'{exp_word(8'h00), exp_word(8'hFF), bus0.in_last, {1'b0, m_lane} + 3'd1});
      m_valid <= 1'b1;
      m_lane  <= '0;
    end else begin
      if (m_acc) begin
        m_pix[m_lane] <= bus0.in_pix;
        m_lane        <= m_lane + 2'd1;
      end
      if (m_valid && bus0.out_ready) m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (n_rst) begin
      checks++;
      if (bus0.out_valid !== m_valid || bus1.out_valid !== m_valid) begin
        errors++;
        $display("FAIL out_valid: got %b/%b expected %b at %0t", bus0.out_valid, bus1.out_valid, m_valid, $time);
      end
      checks++;
      if (bus0.in_ready !== m_rdy || bus1.in_ready !== m_rdy) begin
        errors++;
        $display("FAIL in_ready: got %b/%b expected %b at %0t", bus0.in_ready, bus1.in_ready, m_rdy, $time);
      end
      if (m_valid && bus0.out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: word %h pushed with nothing expected", bus0.out_word);
        end else begin
          if (bus0.out_word !== sb_q[0].w0 || bus1.out_word !== sb_q[0].w1 ||
              bus0.out_last !== sb_q[0].last || bus1.out_last !== sb_q[0].last ||
              bus0.out_bytes !== sb_q[0].bytes || bus1.out_bytes !== sb_q[0].bytes) begin
            errors++;
            $display("FAIL word: got %h/%h last %b bytes %0d expected %h/%h last %b bytes %0d",
                     bus0.out_word, bus1.out_word, bus0.out_last, bus0.out_bytes,
                     sb_q[0].w0, sb_q[0].w1, sb_q[0].last, sb_q[0].bytes);
          end
          sb_q.pop_front();
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input pixel_t p, input logic last);
    int   waits;
    logic r;
    waits = 0;
    bus0.in_valid = 1'b1;
    bus0.in_pix   = p;
    bus0.in_last  = last;
    do begin
      @(negedge clk);
      r = bus0.in_ready;
      @(posedge clk);
      #1;
      if (!r) waits++;
    end while (!r && waits < 50);
    if (!r) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: pixel %h not accepted, in_ready %b required 1", p, r);
    end
    bus0.in_valid = 1'b0;
    bus0.in_last  = 1'b0;
  endtask

  task automatic check_word(input string name, input word_t w0, input word_t w1,
                            input logic last, input byte_cnt_t bytes);
    // Called right after the completing accept: the word must be valid now.
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_word !== w0 || bus1.out_word !== w1 ||
        bus0.out_last !== last || bus0.out_bytes !== bytes) begin
      errors++;
      $display("FAIL %s: got v%b %h/%h last %b bytes %0d expected v1 %h/%h last %b bytes %0d",
               name, bus0.out_valid, bus0.out_word, bus1.out_word, bus0.out_last, bus0.out_bytes,
               w0, w1, last, bytes);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (bus0.out_word !== 32'h0 || bus0.out_valid !== 1'b0 || bus0.out_last !== 1'b0 ||
        bus0.out_bytes !== 3'd0 || bus0.in_ready !== 1'b1 ||
        bus1.out_word !== 32'h0 || bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: got word %h/%h v%b last %b bytes %0d rdy %b required all zero, rdy 1",
               name, bus0.out_word, bus1.out_word, bus0.out_valid, bus0.out_last,
               bus0.out_bytes, bus0.in_ready);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    clear = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.in_pix    = '0;
    bus0.in_last   = 1'b0;
    bus0.out_ready = 1'b0;
    #12;
    check_zero_outputs("reset_state");
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle(1);
  endtask

  task automatic test_full_word();
    bus0.out_ready = 1'b1;
    send_pix(8'h11, 1'b0);
    send_pix(8'h22, 1'b0);
    send_pix(8'h33, 1'b0);
    send_pix(8'h44, 1'b0);
    check_word("full_word", 32'h11223344, 32'h11223344, 1'b0, 3'd4);
    idle(1);
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_word_pulse: out_valid %b required 0", bus0.out_valid);
    end
  endtask

  task automatic test_frame_last();
    bus0.out_ready = 1'b1;
    send_pix(8'hAA, 1'b0);
    send_pix(8'hBB, 1'b0);
    send_pix(8'hCC, 1'b1);
    check_word("partial_last", 32'hAABBCC00, 32'hAABBCCFF, 1'b1, 3'd3);
    send_pix(8'hDD, 1'b0);
    send_pix(8'hEE, 1'b0);
    send_pix(8'hFF, 1'b0);
    send_pix(8'h01, 1'b1);
    check_word("next_frame_lane0", 32'hDDEEFF01, 32'hDDEEFF01, 1'b1, 3'd4);
    idle(2);
  endtask

  task automatic test_backpressure();
    bus0.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_pix(8'h31 + 8'(i), 1'b0);
        #3;
        checks++;
        if (bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall: in_ready %b out_valid %b required 0 and 1", bus0.in_ready, bus0.out_valid);
        end
        for (int i = 4; i < 8; i++) send_pix(8'h31 + 8'(i), 1'b0);
      end
      begin
        repeat (12) @(posedge clk);
        #1;
        bus0.out_ready = 1'b1;
      end
    join
    idle(3);
  endtask

  task automatic test_single_pad();
    bus0.out_ready = 1'b1;
    send_pix(8'h5A, 1'b1);
    check_word("single_pad", 32'h5A000000, 32'h5AFFFFFF, 1'b1, 3'd1);
    idle(2);
  endtask

  task automatic test_clear();
    bus0.out_ready = 1'b1;
    send_pix(8'h61, 1'b0);
    send_pix(8'h62, 1'b0);
    clear         = 1'b1;
    bus0.in_valid = 1'b1;
    bus0.in_pix   = 8'h77;
    @(posedge clk);
    #1;
    clear         = 1'b0;
    bus0.in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) send_pix(8'(i), 1'b0);
    check_word("after_clear", 32'h01020304, 32'h01020304, 1'b0, 3'd4);
    idle(2);
  endtask

  task automatic test_reset_mid();
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_pix(8'h41 + 8'(i), 1'b0);
    send_pix(8'h45, 1'b0);
    send_pix(8'h46, 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    check_zero_outputs("reset_mid_word");
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) send_pix(8'h51 + 8'(i), 1'b0);
    check_word("after_reset", 32'h51525354, 32'h51525354, 1'b0, 3'd4);
    idle(2);
  endtask

`ifdef PIXEL_WORD_PACKER_STATS_EN
  task automatic test_stats();
    bus0.out_ready = 1'b1;
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      send_pix(8'h80 + 8'(k), k == 10);
      checks++;
      if (cnt0 !== 16'(k) || cnt1 !== 16'(k) || ovf0 !== 1'b0) begin
        errors++;
        $display("FAIL stats_count: got %0d/%0d ovf %b expected %0d ovf 0", cnt0, cnt1, ovf0, k);
      end
    end
    idle(1);
    checks++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0 || ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
      errors++;
      $display("FAIL stats_restart: got %0d ovf %b expected 0 ovf 0", cnt0, ovf0);
    end
    idle(2);
  endtask
`endif

  initial begin
    test_reset();
    test_full_word();
    test_frame_last();
    test_backpressure();
    test_single_pad();
    test_clear();
    test_reset_mid();
`ifdef PIXEL_WORD_PACKER_STATS_EN
    test_stats();
`endif
    idle(3);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d words never emitted, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
